tick_generator: RTL and testbench
=================================

# tick_generator

Parametrised multi-channel successor to the control-loop clock divider. Generates N_CH independent single-cycle tick strobes from the 100 MHz system clock, each with a runtime-programmable period and phase offset. Serves the FOC control loop, the ADC sample trigger and the telemetry rate. Configuration changes are glitch-free (shadowed), and a global sync realigns all channels.

## Interface
- N_CH, 3: number of tick channels (1..16)
- W, 16: counter/period/phase width in bits
- DEFAULT_PERIOD, 6250: active period of every channel after reset (100 MHz → 16 kHz)
- clk  in  1  system clock; all logic on rising edge
- nrst  in  1  asynchronous active-low reset
- en  in  N_CH  per-channel run enable
- sync  in  1  global realign strobe, one cycle
- cfg_valid  in  N_CH  per-channel configuration offer
- cfg_ready  out  N_CH  channel can accept a configuration
- cfg_period  in  N_CH×W  offered period in cycles
- cfg_phase  in  N_CH×W  offered phase offset in cycles
- tick  out  N_CH  single-cycle tick strobe, registered
- ack, overrun_clr, overrun: see Configuration

## Operation
- Per-channel state: active period P, active phase F, down-counter C, shadow {P,F} plus pending flag, and run state IDLE/RUN.
- Reset values: tick=0, cfg_ready=all 1, P=DEFAULT_PERIOD, F=0, C=0, pending=0, state=IDLE, overrun=0.
- IDLE→RUN: en=1 sampled in IDLE. On that edge C←F (the pending shadow is applied first if present).
- RUN→IDLE: en=0. On that edge tick←0 and C holds. Re-enabling restarts from F; there is no resume.
- RUN, each cycle:
  - If C==0: tick←1 and C←P−1. If pending, the shadow is applied at this reload, so the new P is used for the reload value, and pending←0.
  - Otherwise: tick←0 and C←C−1.
- P=0: channel emits no ticks and stays in RUN with C held at 0. P=1: tick every cycle.
- F≥P is legal. The first tick is delayed F+1 cycles; later ticks follow normal period P.
- Config handshake: the transfer occurs when cfg_valid&cfg_ready on an edge.
  - cfg_ready=!pending.
  - In IDLE, the shadow is applied on the next edge.
  - In RUN, it is applied at the next reload.
- sync=1: every RUN channel applies any pending shadow, then C←F and tick←0. sync overrides a simultaneous reload. IDLE channels ignore sync.
- Arithmetic is unsigned W-bit. C never wraps below 0.

## Timing
- Start latency: en rises, sampled at edge k. The first tick is high in the cycle after edge k+F+1.
- Steady state: tick is high exactly 1 cycle in every P (P≥1).
- sync sampled at edge k: the next tick is high after edge k+F+1, the same as a start.
- New config accepted at edge k in RUN: the old period completes, and the new P applies from the next tick onward.
- Asynchronous reset mid-count: all state returns to reset values immediately, and tick drops without waiting for a clock.

## Configuration
- Macro TICK_GEN_OVERRUN_EN adds per-channel consumer tracking.
- With the macro defined:
  - Extra ports: ack in N_CH, overrun_clr in N_CH, overrun out N_CH.
  - outstanding←1 on tick and ←0 on ack.
  - A tick issued while outstanding=1, with no ack that same cycle, sets sticky overrun←1.
  - overrun_clr clears overrun. A simultaneous set wins.
- Without the macro: the three ports are absent, no tracking logic is synthesised, and tick behaviour is identical.

## Structure
- Package tick_gen_pkg holds:
  - the W default;
  - DEFAULT_PERIOD;
  - typedef tick_cfg_t {period, phase};
  - the channel-state enum {IDLE, RUN}.
- Sub-module tick_gen_channel contains one channel's counter, shadow and handshake, plus overrun logic under the macro. The top level instantiates N_CH copies and fans out sync.

## Test plan
- Reset, then en[0]=1 with default config → first tick 1 cycle after enable, then every 6250 cycles; tick[1], tick[2]=0 while disabled.
- Ch1 with P=10, F=3: en at edge k → ticks after edges k+4, k+14, k+24. Offer P=4 mid-period → cfg_ready drops, one more 10-cycle gap, then 4-cycle gaps, cfg_ready back to 1.
- sync asserted in the same cycle that ch0 would reload (C==0) → no tick from that reload; next tick F+1 cycles later.
- P=1 gives tick held high continuously. P=0 gives no ticks. en toggled low/high mid-count restarts from F.
- TICK_GEN_OVERRUN_EN, P=5, ack never asserted → overrun sets on the 2nd tick. overrun_clr and tick in the same cycle → overrun stays 1.
- nrst asserted asynchronously mid-count with cfg pending → tick=0 and cfg_ready=1 immediately; P reverts to 6250.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants and types for the multi-channel tick generator.
//   W_DEF          default counter/period/phase width
//   DEFAULT_PERIOD period of every channel after reset (100 MHz -> 16 kHz)
//   tick_cfg_t     {period, phase} configuration record at the default width
//   ch_state_e     per-channel run state
package tick_gen_pkg;
    localparam int W_DEF          = 16;
    localparam int DEFAULT_PERIOD = 6250;

    typedef struct packed {
        logic [W_DEF-1:0] period;
        logic [W_DEF-1:0] phase;
    } tick_cfg_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;
endpackage

// File: rtl/tick_gen_if.sv
// tick_gen_if: control/config/tick bundle between a host and tick_generator.
//   en[N_CH]          per-channel run enable
//   sync              global realign strobe
//   cfg_valid/ready   per-channel config handshake, cfg_period/cfg_phase payload
//   tick[N_CH]        single-cycle tick strobes
//   ack/overrun_clr/overrun  consumer tracking, only with TICK_GEN_OVERRUN_EN
interface tick_gen_if
    import tick_gen_pkg::*;
#(
    parameter int N_CH = 3,
    parameter int W    = W_DEF
);
    logic [N_CH-1:0]        en;
    logic                   sync;
    logic [N_CH-1:0]        cfg_valid;
    logic [N_CH-1:0]        cfg_ready;
    logic [N_CH-1:0][W-1:0] cfg_period;
    logic [N_CH-1:0][W-1:0] cfg_phase;
    logic [N_CH-1:0]        tick;
`ifdef TICK_GEN_OVERRUN_EN
    logic [N_CH-1:0]        ack;
    logic [N_CH-1:0]        overrun_clr;
    logic [N_CH-1:0]        overrun;

    modport master (output en, sync, cfg_valid, cfg_period, cfg_phase, ack, overrun_clr,
                    input  cfg_ready, tick, overrun);
    modport slave  (input  en, sync, cfg_valid, cfg_period, cfg_phase, ack, overrun_clr,
                    output cfg_ready, tick, overrun);
`else
    modport master (output en, sync, cfg_valid, cfg_period, cfg_phase,
                    input  cfg_ready, tick);
    modport slave  (input  en, sync, cfg_valid, cfg_period, cfg_phase,
                    output cfg_ready, tick);
`endif
endinterface

// File: rtl/tick_gen_channel.sv
// tick_gen_channel: one tick channel -- down-counter, shadowed {period, phase}
// with valid/ready handshake, IDLE/RUN state and registered tick strobe.
//   clk, nrst        clock, async active-low reset
//   en, sync         run enable, realign strobe
//   cfg_*            config offer; cfg_ready is low while a shadow is pending
//   tick             single-cycle strobe
//   ack, overrun_clr, overrun   consumer tracking (macro TICK_GEN_OVERRUN_EN)
module tick_gen_channel
    import tick_gen_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int DEFAULT_P = DEFAULT_PERIOD
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en,
    input  logic         sync,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_phase,
`ifdef TICK_GEN_OVERRUN_EN
    input  logic         ack,
    input  logic         overrun_clr,
    output logic         overrun,
`endif
    output logic         tick
);
    // Same layout as tick_cfg_t, resized to this instance's W.
    typedef struct packed {
        logic [W-1:0] period;
        logic [W-1:0] phase;
    } ch_cfg_t;

    ch_state_e    state_q, state_d;
    ch_cfg_t      act_q, shd_q, eff;
    logic         pend_q;
    logic [W-1:0] c_q, c_d;
    logic         tick_d, apply, take;

    assign cfg_ready = !pend_q;
    assign take      = cfg_valid && cfg_ready;
    // Config as it will be after this edge if the shadow gets applied.
    assign eff       = pend_q ? shd_q : act_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en)  state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        apply  = 1'b0;
        tick_d = 1'b0;
        c_d    = c_q;
        case (state_q)
            IDLE: begin
                apply = pend_q;
                if (en) c_d = eff.phase;
            end
            RUN: begin
                if (!en) begin
                    c_d = c_q;                      // stop: count is frozen, restart reloads phase
                end else if (sync) begin
                    apply = pend_q;
                    c_d   = eff.phase;
                end else if (c_q == '0) begin
                    apply = pend_q;
                    if (eff.period != '0) begin     // period 0 parks the channel at C=0
                        tick_d = 1'b1;
                        c_d    = eff.period - W'(1);
                    end
                end else begin
                    c_d = c_q - W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            act_q  <= '{period: W'(DEFAULT_P), phase: '0};
            shd_q  <= '0;
            pend_q <= 1'b0;
            c_q    <= '0;
            tick   <= 1'b0;
        end else begin
            c_q  <= c_d;
            tick <= tick_d;
            if (apply) act_q <= shd_q;
            // take needs !pend_q and apply needs pend_q, so they never coincide.
            if (take) begin
                shd_q  <= '{period: cfg_period, phase: cfg_phase};
                pend_q <= 1'b1;
            end else if (apply) begin
                pend_q <= 1'b0;
            end
        end
    end

`ifdef TICK_GEN_OVERRUN_EN
    logic outstanding;

    // Tracked against the tick being issued at this edge so overrun rises
    // together with the offending tick.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            outstanding <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (tick_d)   outstanding <= 1'b1;
            else if (ack) outstanding <= 1'b0;
            if (tick_d && outstanding && !ack) overrun <= 1'b1;
            else if (overrun_clr)              overrun <= 1'b0;
        end
    end
`endif
endmodule

// File: rtl/tick_generator.sv
// tick_generator: N_CH independent tick channels with programmable period and
// phase, shadowed config and a global sync realign.
//   clk, nrst   system clock, async active-low reset
//   bus         tick_gen_if.slave: en, sync, cfg handshake, tick
//               (+ ack/overrun_clr/overrun with macro TICK_GEN_OVERRUN_EN)
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int N_CH           = 3,
    parameter int W              = tick_gen_pkg::W_DEF,
    parameter int DEFAULT_PERIOD = tick_gen_pkg::DEFAULT_PERIOD
) (
    input logic       clk,
    input logic       nrst,
    tick_gen_if.slave bus
);
    logic [N_CH-1:0] ready_w, tick_w;
`ifdef TICK_GEN_OVERRUN_EN
    logic [N_CH-1:0] overrun_w;
    assign bus.overrun = overrun_w;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tick_gen_channel #(
            .W         (W),
            .DEFAULT_P (DEFAULT_PERIOD)
        ) u_ch (
            .clk        (clk),
            .nrst       (nrst),
            .en         (bus.en[i]),
            .sync       (bus.sync),
            .cfg_valid  (bus.cfg_valid[i]),
            .cfg_ready  (ready_w[i]),
            .cfg_period (bus.cfg_period[i]),
            .cfg_phase  (bus.cfg_phase[i]),
`ifdef TICK_GEN_OVERRUN_EN
            .ack        (bus.ack[i]),
            .overrun_clr(bus.overrun_clr[i]),
            .overrun    (overrun_w[i]),
`endif
            .tick       (tick_w[i])
        );
    end

    assign bus.cfg_ready = ready_w;
    assign bus.tick      = tick_w;
endmodule

// File: tb/tb_tick_generator.sv
module tb_tick_generator;
    import tick_gen_pkg::*;

    localparam int N  = 3;
    localparam int WW = 16;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    tick_gen_if #(.N_CH(N), .W(WW)) bus();
    tick_generator #(.N_CH(N), .W(WW), .DEFAULT_PERIOD(6250)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int ch, input int p, input int f);
        bus.cfg_valid[ch]  = 1'b1;
        bus.cfg_period[ch] = WW'(p);
        bus.cfg_phase[ch]  = WW'(f);
        step();
        bus.cfg_valid[ch]  = 1'b0;
    endtask

    // Edges until tick[ch] is seen high; returns maxn on timeout.
    task automatic wait_tick(input int ch, input int maxn, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.tick[ch] && n < maxn);
    endtask

    typedef struct {
        tick_cfg_t c;
        int        exp_first;   // edges from enable edge to first tick
        int        exp_gap;     // edges between ticks
    } vec_t;

    // Reference model state (time based: absolute edge of next reload)
    int   m_run[N], m_p[N], m_f[N], m_sp[N], m_sf[N], m_pend[N], m_next[N];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int   n, cnt;
        logic [N-1:0] exp_tick, exp_rdy;

        tbl[0] = '{'{16'd10, 16'd3}, 4, 10};
        tbl[1] = '{'{16'd4,  16'd0}, 1, 4};
        tbl[2] = '{'{16'd1,  16'd0}, 1, 1};
        tbl[3] = '{'{16'd7,  16'd9}, 10, 7};
        tbl[4] = '{'{16'd2,  16'd5}, 6, 2};
        tbl[5] = '{'{16'd3,  16'd3}, 4, 3};

        nrst           = 1'b0;
        bus.en         = '0;
        bus.sync       = 1'b0;
        bus.cfg_valid  = '0;
        bus.cfg_period = '0;
        bus.cfg_phase  = '0;
`ifdef TICK_GEN_OVERRUN_EN
        bus.ack         = '0;
        bus.overrun_clr = '0;
`endif
        #12;
        chk("reset_tick", 32'(bus.tick), 0);
        chk("reset_ready", 32'(bus.cfg_ready), 7);
        @(negedge clk) nrst = 1'b1;
        step();

        // Default config on ch0
        bus.en[0] = 1'b1;
        step();
        wait_tick(0, 20, n);
        chk("def_first", n, 1);
        chk("def_others_idle", 32'(bus.tick[2:1]), 0);
        wait_tick(0, 7000, n);
        chk("def_gap", n, 6250);
        bus.en[0] = 1'b0;
        step();

        // Table: period/phase on ch1 from IDLE
        for (int i = 0; i < 6; i++) begin
            offer(1, int'(tbl[i].c.period), int'(tbl[i].c.phase));
            step();
            chk("tbl_ready", 32'(bus.cfg_ready[1]), 1);
            bus.en[1] = 1'b1;
            step();
            wait_tick(1, 60, n);
            chk($sformatf("tbl%0d_first", i), n, tbl[i].exp_first);
            wait_tick(1, 60, n);
            chk($sformatf("tbl%0d_gap", i), n, tbl[i].exp_gap);
            bus.en[1] = 1'b0;
            step();
        end

        // Reconfigure mid-period: P=10 -> P=4
        offer(1, 10, 3);
        step();
        bus.en[1] = 1'b1;
        step();
        wait_tick(1, 60, n);
        chk("mid_first", n, 4);
        repeat (3) step();
        offer(1, 4, 3);
        chk("mid_ready_low", 32'(bus.cfg_ready[1]), 0);
        wait_tick(1, 60, n);
        chk("mid_old_gap", n, 6);           // 4 edges already spent of the 10
        chk("mid_ready_back", 32'(bus.cfg_ready[1]), 1);
        wait_tick(1, 60, n);
        chk("mid_new_gap1", n, 4);
        wait_tick(1, 60, n);
        chk("mid_new_gap2", n, 4);

        // en toggle mid-count restarts from phase
        repeat (2) step();
        bus.en[1] = 1'b0;
        step();
        chk("toggle_tick_off", 32'(bus.tick[1]), 0);
        bus.en[1] = 1'b1;
        step();
        wait_tick(1, 60, n);
        chk("toggle_restart", n, 4);
        bus.en[1] = 1'b0;
        step();

        // sync coinciding with a reload on ch0 (P=5, F=2)
        offer(0, 5, 2);
        step();
        bus.en[0] = 1'b1;
        step();
        wait_tick(0, 60, n);
        chk("sync_first", n, 3);
        repeat (4) step();
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        chk("sync_kills_reload", 32'(bus.tick[0]), 0);
        wait_tick(0, 60, n);
        chk("sync_restart", n, 3);
        wait_tick(0, 60, n);
        chk("sync_then_period", n, 5);
        bus.en[0] = 1'b0;
        step();

        // P=0 never ticks
        offer(2, 0, 0);
        step();
        bus.en[2] = 1'b1;
        step();
        cnt = 0;
        repeat (30) begin
            step();
            if (bus.tick[2]) cnt++;
        end
        chk("p0_no_ticks", cnt, 0);
        bus.en[2] = 1'b0;
        step();

`ifdef TICK_GEN_OVERRUN_EN
        offer(2, 5, 0);
        step();
        bus.en[2] = 1'b1;
        step();
        step();
        chk("ovr_tick1", 32'(bus.tick[2]), 1);
        chk("ovr_clear_first", 32'(bus.overrun[2]), 0);
        repeat (5) step();
        chk("ovr_tick2", 32'(bus.tick[2]), 1);
        chk("ovr_set_2nd", 32'(bus.overrun[2]), 1);
        bus.overrun_clr[2] = 1'b1;
        step();
        bus.overrun_clr[2] = 1'b0;
        chk("ovr_cleared", 32'(bus.overrun[2]), 0);
        repeat (3) step();
        bus.overrun_clr[2] = 1'b1;
        step();
        bus.overrun_clr[2] = 1'b0;
        chk("ovr_tick3", 32'(bus.tick[2]), 1);
        chk("ovr_set_wins", 32'(bus.overrun[2]), 1);
        bus.en[2] = 1'b0;
        step();
`endif

        // Async reset mid-count with a pending config (ch1, P=1 ticks continuously)
        offer(1, 1, 0);
        step();
        bus.en[1] = 1'b1;
        step();
        step();
        chk("ar_tick_before", 32'(bus.tick[1]), 1);
        offer(1, 7, 0);
        chk("ar_pending", 32'(bus.cfg_ready[1]), 0);
        #2 nrst = 1'b0;
        #1;
        chk("ar_tick_drop", 32'(bus.tick), 0);
        chk("ar_ready_all", 32'(bus.cfg_ready), 7);
        @(negedge clk) nrst = 1'b1;
        step();                              // enable still high: restart edge
        wait_tick(1, 20, n);
        chk("ar_first", n, 1);
        wait_tick(1, 7000, n);
        chk("ar_default_period", n, 6250);
        bus.en[1] = 1'b0;

        // Randomized run against the time-based model
        @(negedge clk) nrst = 1'b0;
        @(negedge clk) nrst = 1'b1;
        bus.en = '0;
        for (int c = 0; c < N; c++) begin
            m_run[c] = 0; m_p[c] = 6250; m_f[c] = 0;
            m_sp[c] = 0; m_sf[c] = 0; m_pend[c] = 0; m_next[c] = 0;
        end
        #1;
        for (int t = 0; t < 3000; t++) begin
            bus.sync = ($urandom_range(39) == 0);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(11) == 0) bus.en[c] = ~bus.en[c];
                bus.cfg_valid[c]  = ($urandom_range(7) == 0);
                bus.cfg_period[c] = WW'($urandom_range(12));
                bus.cfg_phase[c]  = WW'($urandom_range(15));
            end
            for (int c = 0; c < N; c++) begin
                int rdy_old;
                rdy_old     = !m_pend[c];
                exp_tick[c] = 1'b0;
                if (!m_run[c]) begin
                    if (m_pend[c] != 0) begin m_p[c] = m_sp[c]; m_f[c] = m_sf[c]; m_pend[c] = 0; end
                    if (bus.en[c]) begin m_run[c] = 1; m_next[c] = t + m_f[c] + 1; end
                end else if (!bus.en[c]) begin
                    m_run[c] = 0;
                end else if (bus.sync) begin
                    if (m_pend[c] != 0) begin m_p[c] = m_sp[c]; m_f[c] = m_sf[c]; m_pend[c] = 0; end
                    m_next[c] = t + m_f[c] + 1;
                end else if (t == m_next[c]) begin
                    if (m_pend[c] != 0) begin m_p[c] = m_sp[c]; m_f[c] = m_sf[c]; m_pend[c] = 0; end
                    if (m_p[c] != 0) begin exp_tick[c] = 1'b1; m_next[c] = t + m_p[c]; end
                    else m_next[c] = t + 1;
                end
                if (bus.cfg_valid[c] && rdy_old != 0) begin
                    m_sp[c] = int'(bus.cfg_period[c]);
                    m_sf[c] = int'(bus.cfg_phase[c]);
                    m_pend[c] = 1;
                end
                exp_rdy[c] = (m_pend[c] == 0);
            end
            step();
            chk($sformatf("rnd_tick@%0d", t), 32'(bus.tick), 32'(exp_tick));
            chk($sformatf("rnd_ready@%0d", t), 32'(bus.cfg_ready), 32'(exp_rdy));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
